// File: rtl/bit_population_counter_pipe_pkg.sv
// Shared constants and sizing helpers for the bit population counter.
// Sizing functions are used at elaboration only.
package bpc_pkg;

    localparam logic MODE_ONES  = 1'b0;
    localparam logic MODE_ZEROS = 1'b1;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic int nib_count(input int w);
        return (w + 3) / 4;
    endfunction

    function automatic int tree_depth(input int w);
        return $clog2(nib_count(w));
    endfunction

    function automatic int latency(input int w);
        return 1 + tree_depth(w);
    endfunction

endpackage

// File: rtl/bit_population_counter_pipe_nibble_count.sv
// Combinational population count of one 4-bit nibble.
module bpc_nibble_count (
    input  logic [3:0] nib,
    output logic [2:0] cnt
);

    always_comb begin
        cnt = 3'(nib[0]) + 3'(nib[1]) + 3'(nib[2]) + 3'(nib[3]);
    end

endmodule

// File: rtl/bit_population_counter_pipe.sv
// Pipelined popcount: registered nibble counts, then one adder-tree level per stage.
// Zeros mode is derived at the output as WIDTH - ones, so padding never counts.
module bit_population_counter_pipe
    import bpc_pkg::*;
#(
    parameter  int WIDTH     = 24,
    parameter  int ACC_WIDTH = 16,
    localparam int CNT_WIDTH = cnt_width(WIDTH)
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic [WIDTH-1:0]     data_i,
    input  logic                 mode_i,
    input  logic                 data_last_i,
    input  logic                 data_val_i,
    output logic                 data_rdy_o,
    output logic [CNT_WIDTH-1:0] data_o,
    output logic [ACC_WIDTH-1:0] total_o,
    output logic                 total_sat_o,
    output logic                 data_last_o,
    output logic                 data_val_o,
    input  logic                 data_rdy_i
);

    localparam int NIB   = nib_count(WIDTH);
    localparam int DEPTH = tree_depth(WIDTH);
    localparam int SW    = (CNT_WIDTH > 3) ? CNT_WIDTH : 3;

    logic                 advance;
    logic                 xfer;
    logic [4*NIB-1:0]     word;
    logic [2:0]           nib_cnt [NIB];
    logic [SW-1:0]        leaf [2*NIB];
    logic [SW-1:0]        node [DEPTH+1][2*NIB];
    logic [DEPTH:0]       vld;
    logic [DEPTH:0]       mode_q;
    logic [DEPTH:0]       last_q;
    logic [SW-1:0]        ones;

    logic [ACC_WIDTH-1:0] acc;
    logic                 sat;
    logic                 fresh;
    logic [ACC_WIDTH:0]   sum;
    logic                 over;

    assign data_rdy_o = data_rdy_i || !data_val_o;
    assign advance    = data_rdy_o;
    assign xfer       = data_val_o && data_rdy_i;

    always_comb begin
        word = '0;
        word[WIDTH-1:0] = data_i;
    end

    for (genvar n = 0; n < NIB; n++) begin : g_nib
        bpc_nibble_count u_cnt (
            .nib (word[4*n +: 4]),
            .cnt (nib_cnt[n])
        );
    end

    // Upper half stays zero so every level can sum pairs without bounds checks.
    always_comb begin
        for (int j = 0; j < 2*NIB; j++) leaf[j] = '0;
        for (int j = 0; j < NIB; j++) leaf[j] = SW'(nib_cnt[j]);
    end

    for (genvar k = 0; k <= DEPTH; k++) begin : g_st
        if (k == 0) begin : g_leaf
            always_ff @(posedge clk_i or negedge arst_n_i) begin
                if (!arst_n_i) begin
                    vld[0]    <= 1'b0;
                    mode_q[0] <= MODE_ONES;
                    last_q[0] <= 1'b0;
                    for (int j = 0; j < 2*NIB; j++) node[0][j] <= '0;
                end else if (advance) begin
                    vld[0]    <= data_val_i;
                    mode_q[0] <= mode_i;
                    last_q[0] <= data_last_i;
                    for (int j = 0; j < 2*NIB; j++) node[0][j] <= leaf[j];
                end
            end
        end else begin : g_sum
            always_ff @(posedge clk_i or negedge arst_n_i) begin
                if (!arst_n_i) begin
                    vld[k]    <= 1'b0;
                    mode_q[k] <= MODE_ONES;
                    last_q[k] <= 1'b0;
                    for (int j = 0; j < 2*NIB; j++) node[k][j] <= '0;
                end else if (advance) begin
                    vld[k]    <= vld[k-1];
                    mode_q[k] <= mode_q[k-1];
                    last_q[k] <= last_q[k-1];
                    for (int j = 0; j < NIB; j++)
                        node[k][j] <= node[k-1][2*j] + node[k-1][2*j+1];
                    for (int j = NIB; j < 2*NIB; j++) node[k][j] <= '0;
                end
            end
        end
    end

    assign ones        = node[DEPTH][0];
    assign data_val_o  = vld[DEPTH];
    assign data_last_o = last_q[DEPTH];
    assign data_o      = (mode_q[DEPTH] == MODE_ZEROS)
                       ? CNT_WIDTH'(WIDTH) - ones[CNT_WIDTH-1:0]
                       : ones[CNT_WIDTH-1:0];

    always_comb begin
        sum = (fresh ? (ACC_WIDTH+1)'(0) : {1'b0, acc})
            + (ACC_WIDTH+1)'(data_o);
        over = sum[ACC_WIDTH];
        total_o = '0;
        total_sat_o = 1'b0;
        if (data_val_o) begin
            total_o = over ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
            total_sat_o = over || (!fresh && sat);
        end
    end

    // Packet state moves only when the downstream actually takes a beat.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            acc   <= '0;
            sat   <= 1'b0;
            fresh <= 1'b1;
        end else if (xfer) begin
            acc   <= total_o;
            sat   <= total_sat_o;
            fresh <= data_last_o;
        end
    end

endmodule

// File: tb/tb_bit_population_counter_pipe.sv
// Bench for bit_population_counter_pipe: directed cases plus randomized
// streams checked against a packet-level reference model.
module tb_bit_population_counter_pipe;

    logic clk = 1'b0;
    logic arst_n = 1'b1;
    always #5 clk = ~clk;

    logic [23:0] d;
    logic        mode, last, val, rdy_i;
    logic [4:0]  cnt;
    logic [15:0] tot;
    logic        sat, last_o, val_o, rdy_o;

    logic [23:0] s_d;
    logic        s_mode, s_last, s_val, s_rdy_i;
    logic [4:0]  s_cnt;
    logic [4:0]  s_tot;
    logic        s_sat, s_last_o, s_val_o, s_rdy_o;

    logic [4:0]  w_d;
    logic        w_mode, w_last, w_val, w_rdy_i;
    logic [2:0]  w_cnt;
    logic [15:0] w_tot;
    logic        w_sat, w_last_o, w_val_o, w_rdy_o;

    bit_population_counter_pipe #(.WIDTH(24), .ACC_WIDTH(16)) dut (
        .clk_i(clk), .arst_n_i(arst_n), .data_i(d), .mode_i(mode),
        .data_last_i(last), .data_val_i(val), .data_rdy_o(rdy_o),
        .data_o(cnt), .total_o(tot), .total_sat_o(sat),
        .data_last_o(last_o), .data_val_o(val_o), .data_rdy_i(rdy_i)
    );

    bit_population_counter_pipe #(.WIDTH(24), .ACC_WIDTH(5)) dut_s (
        .clk_i(clk), .arst_n_i(arst_n), .data_i(s_d), .mode_i(s_mode),
        .data_last_i(s_last), .data_val_i(s_val), .data_rdy_o(s_rdy_o),
        .data_o(s_cnt), .total_o(s_tot), .total_sat_o(s_sat),
        .data_last_o(s_last_o), .data_val_o(s_val_o), .data_rdy_i(s_rdy_i)
    );

    bit_population_counter_pipe #(.WIDTH(5), .ACC_WIDTH(16)) dut_w (
        .clk_i(clk), .arst_n_i(arst_n), .data_i(w_d), .mode_i(w_mode),
        .data_last_i(w_last), .data_val_i(w_val), .data_rdy_o(w_rdy_o),
        .data_o(w_cnt), .total_o(w_tot), .total_sat_o(w_sat),
        .data_last_o(w_last_o), .data_val_o(w_val_o), .data_rdy_i(w_rdy_i)
    );

    int n_total = 0;
    int n_bad = 0;

    typedef struct {
        int cnt;
        int tot;
        bit sat;
        bit last;
    } exp_t;

    exp_t q[$];
    bit   m_new = 1'b1;
    int   m_acc = 0;
    bit   m_sat = 1'b0;

    function automatic int ref_count(input logic [23:0] v, input bit m);
        int c = 0;
        for (int i = 0; i < 24; i++) if (v[i] != m) c++;
        return c;
    endfunction

    // Totals are a property of beat order, so they are fixed at accept time.
    task automatic model_push(input logic [23:0] v, input bit m, input bit l);
        exp_t e;
        int t;
        e.cnt = ref_count(v, m);
        t = m_new ? e.cnt : m_acc + e.cnt;
        e.sat = m_new ? 1'b0 : m_sat;
        if (t > 65535) begin
            t = 65535;
            e.sat = 1'b1;
        end
        e.tot = t;
        e.last = l;
        m_acc = t;
        m_sat = e.sat;
        m_new = l;
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst_n = 1'b0;
        val = 1'b0;
        s_val = 1'b0;
        w_val = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        m_new = 1'b1;
        m_acc = 0;
        m_sat = 1'b0;
        q.delete();
    endtask

    task automatic test_reset();
        d = '0; mode = 1'b0; last = 1'b0; val = 1'b0; rdy_i = 1'b1;
        s_d = '0; s_mode = 1'b0; s_last = 1'b0; s_val = 1'b0; s_rdy_i = 1'b1;
        w_d = '0; w_mode = 1'b0; w_last = 1'b0; w_val = 1'b0; w_rdy_i = 1'b1;
        #2 arst_n = 1'b0;
        #1;
        n_total++;
        if (val_o !== 1'b0) begin
            n_bad++; $display("FAIL reset_val got=%b want=0", val_o);
        end
        n_total++;
        if (cnt !== 5'd0 || tot !== 16'd0) begin
            n_bad++; $display("FAIL reset_data got=%0d/%0d want=0/0", cnt, tot);
        end
        n_total++;
        if (sat !== 1'b0 || last_o !== 1'b0) begin
            n_bad++; $display("FAIL reset_flags got=%b%b want=00", sat, last_o);
        end
        n_total++;
        if (rdy_o !== 1'b1) begin
            n_bad++; $display("FAIL reset_rdy got=%b want=1", rdy_o);
        end
        n_total++;
        if (s_val_o !== 1'b0 || w_val_o !== 1'b0) begin
            n_bad++; $display("FAIL reset_aux got=%b%b want=00", s_val_o, w_val_o);
        end
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic test_ones_latency();
        @(negedge clk);
        d = 24'hFFFFFF; mode = 1'b0; last = 1'b1; val = 1'b1; rdy_i = 1'b1;
        @(negedge clk);
        val = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            n_total++;
            if (val_o !== (k == 4)) begin
                n_bad++;
                $display("FAIL latency_c%0d got=%b want=%b", k, val_o, k == 4);
            end
            if (k < 4) @(negedge clk);
        end
        n_total++;
        if (cnt !== 5'd24 || tot !== 16'd24 || last_o !== 1'b1) begin
            n_bad++;
            $display("FAIL ones_full got=%0d/%0d want=24/24", cnt, tot);
        end
    endtask

    task automatic test_zeros();
        int t;
        @(negedge clk);
        d = 24'h000000; mode = 1'b1; last = 1'b1; val = 1'b1;
        @(negedge clk);
        val = 1'b0; mode = 1'b0;
        t = 0;
        while (val_o !== 1'b1 && t < 10) begin @(negedge clk); t++; end
        n_total++;
        if (val_o !== 1'b1 || cnt !== 5'd24 || tot !== 16'd24) begin
            n_bad++;
            $display("FAIL zeros24 got=%b/%0d/%0d want=1/24/24", val_o, cnt, tot);
        end
        w_d = 5'd0; w_mode = 1'b1; w_last = 1'b1; w_val = 1'b1;
        @(negedge clk);
        w_val = 1'b0;
        t = 0;
        while (w_val_o !== 1'b1 && t < 10) begin @(negedge clk); t++; end
        n_total++;
        if (w_val_o !== 1'b1 || w_cnt !== 3'd5) begin
            n_bad++; $display("FAIL zeros5 got=%b/%0d want=1/5", w_val_o, w_cnt);
        end
        @(negedge clk);
        w_d = 5'b10110; w_mode = 1'b0; w_last = 1'b1; w_val = 1'b1;
        @(negedge clk);
        w_val = 1'b0;
        t = 0;
        while (w_val_o !== 1'b1 && t < 10) begin @(negedge clk); t++; end
        n_total++;
        if (w_val_o !== 1'b1 || w_cnt !== 3'd3 || w_tot !== 16'd3) begin
            n_bad++; $display("FAIL ones5 got=%0d/%0d want=3/3", w_cnt, w_tot);
        end
    endtask

    task automatic test_packet();
        logic [23:0] beats [4] = '{24'hFFFFFF, 24'h000001, 24'h0000F0, 24'h00000F};
        bit   lasts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int   ecnt [4] = '{24, 1, 4, 4};
        int   etot [4] = '{24, 25, 29, 4};
        int   sent = 0;
        int   got = 0;
        int   t = 0;
        rdy_i = 1'b1;
        while (got < 4 && t < 40) begin
            @(negedge clk);
            t++;
            if (val_o === 1'b1) begin
                n_total++;
                if (cnt !== 5'(ecnt[got]) || tot !== 16'(etot[got])
                    || last_o !== lasts[got]) begin
                    n_bad++;
                    $display("FAIL packet_b%0d got=%0d/%0d/%b want=%0d/%0d/%b",
                             got, cnt, tot, last_o, ecnt[got], etot[got], lasts[got]);
                end
                got++;
            end
            if (sent < 4) begin
                d = beats[sent]; mode = 1'b0; last = lasts[sent]; val = 1'b1;
                sent++;
            end else begin
                val = 1'b0;
            end
        end
        val = 1'b0;
        n_total++;
        if (got != 4) begin
            n_bad++; $display("FAIL packet_count got=%0d want=4", got);
        end
    endtask

    task automatic test_saturate();
        logic [23:0] beats [3] = '{24'hFFFFFF, 24'hFFFFFF, 24'h00000F};
        bit   lasts [3] = '{1'b0, 1'b1, 1'b1};
        int   etot [3] = '{24, 31, 4};
        bit   esat [3] = '{1'b0, 1'b1, 1'b0};
        int   sent = 0;
        int   got = 0;
        int   t = 0;
        while (got < 3 && t < 40) begin
            @(negedge clk);
            t++;
            if (s_val_o === 1'b1) begin
                n_total++;
                if (s_tot !== 5'(etot[got]) || s_sat !== esat[got]) begin
                    n_bad++;
                    $display("FAIL sat_b%0d got=%0d/%b want=%0d/%b",
                             got, s_tot, s_sat, etot[got], esat[got]);
                end
                got++;
            end
            if (sent < 3) begin
                s_d = beats[sent]; s_last = lasts[sent]; s_val = 1'b1;
                sent++;
            end else begin
                s_val = 1'b0;
            end
        end
        s_val = 1'b0;
        n_total++;
        if (got != 3) begin
            n_bad++; $display("FAIL sat_count got=%0d want=3", got);
        end
    endtask

    task automatic test_stream(input int n, input bit cont, input int st0,
                               input int stn, input bit rnd_rdy);
        int   sent = 0;
        int   cyc = 0;
        int   stall_low = 0;
        bit   took = 1'b1;
        bit   held = 1'b0;
        logic [4:0]  h_cnt;
        logic [15:0] h_tot;
        logic        h_sat, h_last;
        exp_t e;
        do_reset();
        while ((sent < n || q.size() > 0) && cyc < n*6 + 100) begin
            @(negedge clk);
            if (sent < n) begin
                if (took || !val) begin
                    val  = cont ? 1'b1 : ($urandom_range(3) != 0);
                    d    = 24'($urandom);
                    mode = 1'($urandom);
                    last = ($urandom_range(2) == 0);
                end
            end else begin
                val = 1'b0;
            end
            if (cyc >= st0 && cyc < st0 + stn) rdy_i = 1'b0;
            else rdy_i = rnd_rdy ? ($urandom_range(3) != 0) : 1'b1;
            #1;
            n_total++;
            if (rdy_o !== (rdy_i || !val_o)) begin
                n_bad++;
                $display("FAIL rdy_eq c%0d got=%b want=%b", cyc, rdy_o, rdy_i || !val_o);
            end
            if (cyc >= st0 && cyc < st0 + stn && rdy_o === 1'b0) stall_low++;
            if (held) begin
                n_total++;
                if (val_o !== 1'b1 || cnt !== h_cnt || tot !== h_tot
                    || sat !== h_sat || last_o !== h_last) begin
                    n_bad++;
                    $display("FAIL hold c%0d got=%0d/%0d want=%0d/%0d",
                             cyc, cnt, tot, h_cnt, h_tot);
                end
            end
            held = (val_o === 1'b1) && !rdy_i;
            h_cnt = cnt; h_tot = tot; h_sat = sat; h_last = last_o;
            if (val_o === 1'b1 && rdy_i) begin
                n_total++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL extra_beat c%0d got=%0d want=none", cyc, cnt);
                end else begin
                    e = q.pop_front();
                    if (cnt !== 5'(e.cnt) || tot !== 16'(e.tot)
                        || sat !== e.sat || last_o !== e.last) begin
                        n_bad++;
                        $display("FAIL beat c%0d got=%0d/%0d/%b/%b want=%0d/%0d/%b/%b",
                                 cyc, cnt, tot, sat, last_o, e.cnt, e.tot, e.sat, e.last);
                    end
                end
            end
            took = val && rdy_o;
            if (took) begin
                model_push(d, mode, last);
                sent++;
            end
            cyc++;
        end
        val = 1'b0;
        rdy_i = 1'b1;
        n_total++;
        if (sent != n || q.size() != 0) begin
            n_bad++;
            $display("FAIL stream_drain got=%0d/%0d want=%0d/0", sent, q.size(), n);
        end
        n_total++;
        if (stall_low != stn) begin
            n_bad++; $display("FAIL stall_rdy got=%0d want=%0d", stall_low, stn);
        end
    endtask

    task automatic test_back_to_back();
        test_stream(60, 1'b0, 0, 0, 1'b1);
        test_stream(40, 1'b1, 0, 0, 1'b0);
    endtask

    task automatic test_stall();
        test_stream(40, 1'b1, 12, 5, 1'b0);
    endtask

    task automatic test_reset_inflight();
        int seen = 0;
        int t = 0;
        rdy_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            d = 24'hFFFFFF; mode = 1'b0; last = 1'b0; val = 1'b1;
        end
        @(negedge clk);
        val = 1'b0;
        n_total++;
        if (val_o !== 1'b1) begin
            n_bad++; $display("FAIL inflight_pre got=%b want=1", val_o);
        end
        #1 arst_n = 1'b0;
        #1;
        n_total++;
        if (val_o !== 1'b0 || cnt !== 5'd0 || tot !== 16'd0 || rdy_o !== 1'b1) begin
            n_bad++;
            $display("FAIL inflight_rst got=%b/%0d/%0d/%b want=0/0/0/1",
                     val_o, cnt, tot, rdy_o);
        end
        @(negedge clk);
        arst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (val_o === 1'b1) seen++;
        end
        n_total++;
        if (seen != 0) begin
            n_bad++; $display("FAIL stale_beats got=%0d want=0", seen);
        end
        d = 24'h0000FF; mode = 1'b0; last = 1'b1; val = 1'b1;
        @(negedge clk);
        val = 1'b0;
        while (val_o !== 1'b1 && t < 10) begin @(negedge clk); t++; end
        n_total++;
        if (val_o !== 1'b1 || cnt !== 5'd8 || tot !== 16'd8) begin
            n_bad++;
            $display("FAIL post_reset got=%b/%0d/%0d want=1/8/8", val_o, cnt, tot);
        end
    endtask

    initial begin
        test_reset();
        test_ones_latency();
        test_zeros();
        test_packet();
        test_saturate();
        test_back_to_back();
        test_stall();
        test_reset_inflight();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
